// File: rtl/icache_refill.sv
// Instruction-cache line refill: one 8-beat AXI read burst per miss, words steered to banks, tag written last.
// Build option: ICACHE_CRITICAL_WORD_FIRST_EN selects a WRAP burst that starts at the missed word.
module icache_refill #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        miss_ack,
  output logic [7:0]  ram_wen,
  output logic [6:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        tag_wen,
  output logic [20:0] tag_wdata,
  output logic        crit_valid,
  output logic [31:0] crit_data,
  output logic        refill_done,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr;
  logic        err;
  logic [2:0]  cnt;
  logic [2:0]  start_off;
  logic [2:0]  off;
  logic        beat;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_off = addr[4:2];
  assign araddr    = {addr[31:2], 2'b00};
  assign arburst   = 2'b10;
`else
  assign start_off = 3'd0;
  assign araddr    = {addr[31:5], 5'b0};
  assign arburst   = 2'b01;
`endif

  assign arid     = ARID_VAL;
  assign arlen    = 8'd7;
  assign arsize   = 3'b010;
  assign ram_addr = addr[11:5];
  assign beat     = (state == R) && rvalid;
  assign off      = start_off + cnt;

  // The beat count alone ends the burst; rid and rlast are not trusted.
  logic unused;
  assign unused = ^{rid, rlast, addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_req) state_nxt = AR;
      AR:      if (arready) state_nxt = R;
      R:       if (beat && cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      err  <= 1'b0;
      cnt  <= '0;
    end else if (state == IDLE && miss_req) begin
      addr <= miss_addr;
      err  <= 1'b0;
      cnt  <= '0;
    end else if (beat) begin
      cnt <= cnt + 3'd1;
      if (rresp != 2'b00) err <= 1'b1;
    end
  end

  always_comb begin
    miss_ack    = (state == IDLE) && miss_req;
    arvalid     = (state == AR);
    rready      = (state == R);
    ram_wen     = '0;
    ram_wdata   = '0;
    crit_valid  = 1'b0;
    crit_data   = '0;
    tag_wen     = 1'b0;
    tag_wdata   = '0;
    refill_done = 1'b0;
    if (beat) begin
      ram_wen   = 8'b1 << off;
      ram_wdata = rdata;
      if (off == addr[4:2]) begin
        crit_valid = 1'b1;
        crit_data  = rdata;
      end
    end
    if (state == DONE) begin
      tag_wen     = 1'b1;
      tag_wdata   = {~err, addr[31:12]};
      refill_done = 1'b1;
    end
  end

endmodule
